// File: rtl/regwrite_arbiter.sv
// Arbitrates the single regfile write port between the writeback stage (A, priority)
// and a buffered secondary writer (B) with a starvation guard that stalls A for one cycle.
module regwrite_arbiter #(
  parameter int WIDTH      = 8,
  parameter int ADDRW      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [ADDRW-1:0] a_addr,
  input  logic [WIDTH-1:0] a_data,
  output logic             stall_a,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [ADDRW-1:0] b_addr,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_done,
  output logic             we3,
  output logic [ADDRW-1:0] wa3,
  output logic [WIDTH-1:0] wd3,
  output logic             err
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FORCE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [ADDRW-1:0] buf_addr;
  logic [WIDTH-1:0] buf_data;

  logic          handshake;
  logic          cancel;
  logic [CW-1:0] cnt_inc;

  assign b_ready = (state == IDLE) & reset;

  always_comb begin
    handshake = b_valid & b_ready;
    cancel    = (state == HOLD) & a_valid & (a_addr == buf_addr);
    cnt_inc   = cnt;
    if (cnt != CNT_MAX) cnt_inc = cnt + 1'b1;
  end

  // Register 0 is hardwired in the regfile, so writes to it are consumed but never enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      buf_addr <= '0;
      buf_data <= '0;
      stall_a  <= 1'b0;
      b_done   <= 1'b0;
      we3      <= 1'b0;
      wa3      <= '0;
      wd3      <= '0;
      err      <= 1'b0;
    end else begin
      stall_a <= 1'b0;
      b_done  <= 1'b0;
      we3     <= 1'b0;
      unique case (state)
        FORCE: begin
          we3    <= (buf_addr != '0);
          wa3    <= buf_addr;
          wd3    <= buf_data;
          b_done <= 1'b1;
          state  <= IDLE;
          if (a_valid) err <= 1'b1;
        end
        HOLD: begin
          if (a_valid) begin
            we3 <= (a_addr != '0);
            wa3 <= a_addr;
            wd3 <= a_data;
            if (cancel) begin
              b_done <= 1'b1;
              state  <= IDLE;
            end else begin
              cnt <= cnt_inc;
              if (cnt_inc == CNT_MAX) begin
                state   <= FORCE;
                stall_a <= 1'b1;
              end
            end
          end else begin
            we3    <= (buf_addr != '0);
            wa3    <= buf_addr;
            wd3    <= buf_data;
            b_done <= 1'b1;
            state  <= IDLE;
          end
        end
        default: begin
          if (a_valid) begin
            we3 <= (a_addr != '0);
            wa3 <= a_addr;
            wd3 <= a_data;
          end
          if (handshake) begin
            buf_addr <= b_addr;
            buf_data <= b_data;
            cnt      <= '0;
            state    <= HOLD;
          end
        end
      endcase
    end
  end

endmodule
